storage_write_sequencer: RTL and testbench
==========================================

// Module: storage_write_sequencer
// PURPOSE
//  Host-side writer for the data path storages. Consumes a byte stream from the host link (valid/ready)
//  and decodes packets into single-cycle write strobes for the code, weight, input and label storages.
//  Also issues the locator-reset and controller-enable pulses. Sits between the host receiver and data_path.
// PARAMETERS
//  DATA_W   48  matrix element width (weight/input/label row word)
//  CODE_W   12  code word width
//  IDX_W    32  layer/row/line index width on the storage ports
// PORTS
//  clk_clk                  in   1       single clock domain
//  reset_reset_n            in   1       synchronous, active-low reset
//  in_data                  in   8       host byte
//  in_valid / in_ready      in/out 1/1   byte handshake; transfer when both high
//  code_is_write            out  1       one-cycle strobe
//  code_write_line          out  IDX_W   code line address
//  code_write_data          out  CODE_W  code word
//  weight_is_write, input_is_write, label_is_write  out 1 each  one-cycle strobes, one-hot
//  mat_write_layer_index    out  IDX_W   shared by weight/input/label writes
//  mat_write_row_index      out  IDX_W   shared
//  mat_write_data           out  DATA_W  shared
//  locator_reset            out  1       one-cycle pulse (to matrix_storage_locator_reset)
//  controller_enable        out  1       one-cycle pulse (to controller_enable)
//  busy                     out  1       high whenever state != IDLE
//  err                      out  1       sticky error flag; cleared only by reset
// BEHAVIOUR
//  Packet: HDR(1) | LAYER(2,BE) | ROW(2,BE) | CNT(1) | CNT elements. HDR[2:0]: 0 code, 1 weight,
//   2 input, 3 label, 4 locator reset, 5 controller enable; HDR[7:3] ignored. CNT=0 means 256.
//  Header-only commands 4/5: pulse the output one cycle after the HDR handshake; no further bytes consumed.
//  Element size: 6 bytes BE for matrix targets, 2 bytes BE for code (upper 4 bits discarded).
//  LAYER/ROW are zero-extended to IDX_W. Code: line starts at {LAYER,ROW}, +1 per element.
//   Matrix: layer fixed, row starts at ROW, +1 per element; 32-bit wrap is modulo.
//  FSM: IDLE -> HDR_DONE -> LAYER(2 bytes) -> ROW(2) -> CNT -> ELEM(k bytes) -> WRITE -> ELEM | IDLE.
//  WRITE lasts exactly 1 cycle. The strobe and its address/data are valid together in that cycle, and
//   in_ready=0 during it. Latency: last element byte accepted at cycle t -> strobe at t+1.
//  in_ready=1 in every other state, including IDLE. Outputs are registered.
//   Address/data hold their last value between strobes.
//  HDR[2:0] in 6..7: byte consumed, err<=1, stay IDLE.
//  Stalls (in_valid low) are legal anywhere; no timeout.
//  Reset value: all strobes/pulses 0; addresses/data 0; busy 0; err 0; in_ready 0 during reset, 1 after.
//  Reset mid-packet: FSM to IDLE, partial element dropped, no strobe.
// CONFIGURATION
//  SWSEQ_CHECKSUM_EN defined: after the last element, one extra byte = XOR of all prior packet bytes
//   (HDR included), consumed in state CSUM. Mismatch -> err<=1. Writes already issued are not retracted.
//   Commands 4/5 have no checksum byte.
//  Undefined: no CSUM state; packet ends after the last WRITE.
// STRUCTURE
//  storage_write_pkg: target enum (TGT_CODE..TGT_ENABLE), state enum, element byte-count constants.
//  Sub-module byte_assembler: shift register taking up to 6 BE bytes, with byte counter and done flag.
//   It is reused for the LAYER/ROW/CNT fields.
// TESTING
//  1. Weight packet 01 0002 0005 02, elems 000100020003 / 0000000000FF -> weight_is_write twice:
//     layer=2, row=5 then row=6, data as sent; no other strobes.
//  2. Code packet 00 0000 0010 03, elems 0ABC/FFFF/0123 -> code lines 0x10,0x11,0x12;
//     data 0xABC,0xFFF,0x123.
//  3. HDR 04, then HDR 05 -> locator_reset one cycle, then controller_enable one cycle;
//     busy returns 0 after each pulse.
//  4. Random in_valid gaps (50%) on test 1 -> identical strobes; in_ready=0 exactly in each WRITE cycle.
//  5. HDR 07 -> err=1, no strobes. Reset asserted mid-element of a label packet -> no strobe;
//     next packet written correctly.
//  6. With SWSEQ_CHECKSUM_EN: test 1 plus correct XOR -> err stays 0; corrupted byte -> err=1,
//     both writes still issued.

Source files
------------

// File: rtl/storage_write_pkg.sv
// storage_write_pkg
//   Shared types and constants for storage_write_sequencer and its byte assembler.
//   Target encoding matches HDR[2:0] of a host packet.
//   Build option: SWSEQ_CHECKSUM_EN adds the ST_CSUM state (trailing XOR byte per data packet).
package storage_write_pkg;

  typedef enum logic [2:0] {
    TGT_CODE   = 3'd0,
    TGT_WEIGHT = 3'd1,
    TGT_INPUT  = 3'd2,
    TGT_LABEL  = 3'd3,
    TGT_RESET  = 3'd4,
    TGT_ENABLE = 3'd5,
    TGT_RSVD6  = 3'd6,
    TGT_RSVD7  = 3'd7
  } tgt_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR_DONE = 3'd1,
    ST_LAYER    = 3'd2,
    ST_ROW      = 3'd3,
    ST_CNT      = 3'd4,
    ST_ELEM     = 3'd5,
    ST_WRITE    = 3'd6
`ifdef SWSEQ_CHECKSUM_EN
    ,
    ST_CSUM     = 3'd7
`endif
  } state_e;

  localparam logic [2:0] CODE_ELEM_BYTES = 3'd2;
  localparam logic [2:0] MAT_ELEM_BYTES  = 3'd6;
  localparam logic [2:0] IDX_FIELD_BYTES = 3'd2;
  localparam logic [2:0] CNT_FIELD_BYTES = 3'd1;

  function automatic logic [2:0] elem_bytes(input tgt_e t);
    return (t == TGT_CODE) ? CODE_ELEM_BYTES : MAT_ELEM_BYTES;
  endfunction

  // Header-only commands: no address, count or element bytes follow.
  function automatic logic is_cmd(input tgt_e t);
    return (t == TGT_RESET) || (t == TGT_ENABLE);
  endfunction

  function automatic logic is_valid_tgt(input tgt_e t);
    return (t != TGT_RSVD6) && (t != TGT_RSVD7);
  endfunction

endpackage

// File: rtl/storage_write_sequencer_byte_assembler.sv
// byte_assembler
//   Big-endian shift register collecting up to 6 bytes into one word.
//   'word' already includes the byte being accepted this cycle, so the caller can
//   capture a complete field in the same cycle 'done' is high.
// Ports
//   clk_clk, reset_reset_n : clock, synchronous active-low reset
//   clear                  : restart the byte counter
//   accept                 : a byte is transferred this cycle
//   byte_in                : the byte
//   len                    : field length in bytes (1..6)
//   word                   : assembled value, last byte in [7:0]
//   done                   : this accepted byte completes the field
module byte_assembler
  import storage_write_pkg::*;
(
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  input  logic [2:0]  len,
  output logic [47:0] word,
  output logic        done
);

  logic [39:0] shift_q;
  logic [2:0]  count_q;

  assign word = {shift_q, byte_in};
  assign done = accept && (count_q == (len - 3'd1));

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (accept) begin
      shift_q <= word[39:0];
      count_q <= done ? 3'd0 : count_q + 3'd1;
    end
  end

endmodule

// File: rtl/storage_write_sequencer.sv
// storage_write_sequencer
//   Decodes host byte packets  HDR | LAYER(2) | ROW(2) | CNT | elements
//   into single-cycle write strobes for the code/weight/input/label storages,
//   plus locator-reset and controller-enable pulses.
//   Build option: SWSEQ_CHECKSUM_EN -> each data packet ends with an XOR byte
//   checked in ST_CSUM; a mismatch sets err.
//
// state       | meaning
// ST_IDLE     | waiting for a header byte
// ST_HDR_DONE | header taken; pulse cycle for commands, else first LAYER byte
// ST_LAYER    | collecting LAYER
// ST_ROW      | collecting ROW
// ST_CNT      | collecting CNT (0 = 256 elements)
// ST_ELEM     | collecting one element (2 or 6 bytes)
// ST_WRITE    | strobe cycle, in_ready low
// ST_CSUM     | checksum byte (SWSEQ_CHECKSUM_EN only)
//
// Ports
//   clk_clk, reset_reset_n      : clock, synchronous active-low reset
//   in_data/in_valid/in_ready   : host byte stream
//   code_*                      : code storage write port
//   weight/input/label_is_write : one-hot matrix write strobes
//   mat_write_*                 : shared matrix address/data
//   locator_reset               : one-cycle pulse
//   controller_enable           : one-cycle pulse
//   busy                        : FSM not idle
//   err                         : sticky bad-header / checksum error
module storage_write_sequencer
  import storage_write_pkg::*;
#(
  parameter int DATA_W = 48,
  parameter int CODE_W = 12,
  parameter int IDX_W  = 32
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              code_is_write,
  output logic [IDX_W-1:0]  code_write_line,
  output logic [CODE_W-1:0] code_write_data,
  output logic              weight_is_write,
  output logic              input_is_write,
  output logic              label_is_write,
  output logic [IDX_W-1:0]  mat_write_layer_index,
  output logic [IDX_W-1:0]  mat_write_row_index,
  output logic [DATA_W-1:0] mat_write_data,
  output logic              locator_reset,
  output logic              controller_enable,
  output logic              busy,
  output logic              err
);

  state_e     state_q, state_next;
  tgt_e       tgt_q, tgt_next, hdr_tgt;
  logic       hs;
  logic       asm_accept, asm_done;
  logic [2:0] field_len;
  logic [47:0] asm_word;
  logic       ready_next;

  logic [15:0]      layer_q;
  logic [IDX_W-1:0] addr_q;
  logic [8:0]       elem_left_q;
`ifdef SWSEQ_CHECKSUM_EN
  logic [7:0]       csum_q;
`endif

  assign hs      = in_valid && in_ready;
  assign hdr_tgt = tgt_e'(in_data[2:0]);

  byte_assembler u_asm (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .clear         (state_q == ST_IDLE),
    .accept        (asm_accept),
    .byte_in       (in_data),
    .len           (field_len),
    .word          (asm_word),
    .done          (asm_done)
  );

  always_comb begin
    state_next = state_q;
    field_len  = IDX_FIELD_BYTES;
    asm_accept = 1'b0;

    case (state_q)
      ST_HDR_DONE, ST_LAYER, ST_ROW: field_len = IDX_FIELD_BYTES;
      ST_CNT:                        field_len = CNT_FIELD_BYTES;
      ST_ELEM:                       field_len = elem_bytes(tgt_q);
      default:                       field_len = IDX_FIELD_BYTES;
    endcase

    case (state_q)
      ST_HDR_DONE, ST_LAYER, ST_ROW, ST_CNT, ST_ELEM: asm_accept = hs;
      default:                                        asm_accept = 1'b0;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (hs && is_valid_tgt(hdr_tgt)) state_next = ST_HDR_DONE;
      end
      ST_HDR_DONE: begin
        // A data target may already deliver its first LAYER byte here.
        if (is_cmd(tgt_q)) state_next = ST_IDLE;
        else if (hs)       state_next = ST_LAYER;
      end
      ST_LAYER: if (asm_done) state_next = ST_ROW;
      ST_ROW:   if (asm_done) state_next = ST_CNT;
      ST_CNT:   if (asm_done) state_next = ST_ELEM;
      ST_ELEM:  if (asm_done) state_next = ST_WRITE;
      ST_WRITE: begin
        if (elem_left_q != 9'd0) state_next = ST_ELEM;
`ifdef SWSEQ_CHECKSUM_EN
        else                     state_next = ST_CSUM;
`else
        else                     state_next = ST_IDLE;
`endif
      end
`ifdef SWSEQ_CHECKSUM_EN
      ST_CSUM:  if (hs) state_next = ST_IDLE;
`endif
      default:  state_next = ST_IDLE;
    endcase

    tgt_next = (state_q == ST_IDLE && hs) ? hdr_tgt : tgt_q;
    // in_ready is registered, so it is derived from the state being entered.
    // The pulse cycle of a header-only command takes no byte: it would have
    // nowhere to go.
    ready_next = (state_next != ST_WRITE) &&
                 !(state_next == ST_HDR_DONE && is_cmd(tgt_next));
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q               <= ST_IDLE;
      tgt_q                 <= TGT_CODE;
      in_ready              <= 1'b0;
      busy                  <= 1'b0;
      err                   <= 1'b0;
      code_is_write         <= 1'b0;
      code_write_line       <= '0;
      code_write_data       <= '0;
      weight_is_write       <= 1'b0;
      input_is_write        <= 1'b0;
      label_is_write        <= 1'b0;
      mat_write_layer_index <= '0;
      mat_write_row_index   <= '0;
      mat_write_data        <= '0;
      locator_reset         <= 1'b0;
      controller_enable     <= 1'b0;
      layer_q               <= '0;
      addr_q                <= '0;
      elem_left_q           <= '0;
`ifdef SWSEQ_CHECKSUM_EN
      csum_q                <= '0;
`endif
    end else begin
      state_q  <= state_next;
      tgt_q    <= tgt_next;
      in_ready <= ready_next;
      busy     <= (state_next != ST_IDLE);

      code_is_write     <= 1'b0;
      weight_is_write   <= 1'b0;
      input_is_write    <= 1'b0;
      label_is_write    <= 1'b0;
      locator_reset     <= 1'b0;
      controller_enable <= 1'b0;

`ifdef SWSEQ_CHECKSUM_EN
      if (hs) csum_q <= (state_q == ST_IDLE) ? in_data : (csum_q ^ in_data);
`endif

      case (state_q)
        ST_IDLE: begin
          if (hs) begin
            if (hdr_tgt == TGT_RESET)  locator_reset     <= 1'b1;
            if (hdr_tgt == TGT_ENABLE) controller_enable <= 1'b1;
            if (!is_valid_tgt(hdr_tgt)) err <= 1'b1;
          end
        end
        ST_LAYER: if (asm_done) layer_q <= asm_word[15:0];
        ST_ROW: begin
          if (asm_done) begin
            // Code lines use {LAYER,ROW} as one address; matrix rows use ROW only.
            if (tgt_q == TGT_CODE) addr_q <= IDX_W'({layer_q, asm_word[15:0]});
            else                   addr_q <= IDX_W'(asm_word[15:0]);
          end
        end
        ST_CNT: begin
          if (asm_done)
            elem_left_q <= (asm_word[7:0] == 8'd0) ? 9'd256 : {1'b0, asm_word[7:0]};
        end
        ST_ELEM: begin
          if (asm_done) begin
            elem_left_q <= elem_left_q - 9'd1;
            addr_q      <= addr_q + IDX_W'(1);
            if (tgt_q == TGT_CODE) begin
              code_is_write   <= 1'b1;
              code_write_line <= addr_q;
              code_write_data <= asm_word[CODE_W-1:0];
            end else begin
              weight_is_write       <= (tgt_q == TGT_WEIGHT);
              input_is_write        <= (tgt_q == TGT_INPUT);
              label_is_write        <= (tgt_q == TGT_LABEL);
              mat_write_layer_index <= IDX_W'(layer_q);
              mat_write_row_index   <= addr_q;
              mat_write_data        <= DATA_W'(asm_word);
            end
          end
        end
`ifdef SWSEQ_CHECKSUM_EN
        ST_CSUM: if (hs && (in_data != csum_q)) err <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_storage_write_sequencer.sv
// Scoreboard bench for storage_write_sequencer. Stimulus pushes expected strobes
// into a queue; the negedge monitor pops and compares on every strobe/pulse.
// Honours SWSEQ_CHECKSUM_EN by appending the XOR byte to data packets.
module tb_storage_write_sequencer;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        code_is_write;
  logic [31:0] code_write_line;
  logic [11:0] code_write_data;
  logic        weight_is_write, input_is_write, label_is_write;
  logic [31:0] mat_write_layer_index, mat_write_row_index;
  logic [47:0] mat_write_data;
  logic        locator_reset, controller_enable, busy, err;

  always #5 clk_clk = ~clk_clk;

  storage_write_sequencer dut (
    .clk_clk               (clk_clk),
    .reset_reset_n         (reset_reset_n),
    .in_data               (in_data),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .code_is_write         (code_is_write),
    .code_write_line       (code_write_line),
    .code_write_data       (code_write_data),
    .weight_is_write       (weight_is_write),
    .input_is_write        (input_is_write),
    .label_is_write        (label_is_write),
    .mat_write_layer_index (mat_write_layer_index),
    .mat_write_row_index   (mat_write_row_index),
    .mat_write_data        (mat_write_data),
    .locator_reset         (locator_reset),
    .controller_enable     (controller_enable),
    .busy                  (busy),
    .err                   (err)
  );

  typedef struct {
    int          kind;   // 0 code,1 weight,2 input,3 label,4 locator reset,5 enable
    logic [31:0] layer;
    logic [31:0] addr;
    logic [47:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] pkt[$];
  int         tests = 0;
  int         fails = 0;
  bit         cnt_rdy = 0;
  int         rdy_low = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, expv);
    end
  endtask

  task automatic exp_push(input int kind, input logic [31:0] layer,
                          input logic [31:0] addr, input logic [47:0] data);
    exp_t e;
    e.kind = kind; e.layer = layer; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: every strobe/pulse cycle must match the head of the scoreboard.
  int   mon_n, mon_k;
  exp_t mon_got, mon_exp;
  always @(negedge clk_clk) begin
    if (reset_reset_n) begin
      if (cnt_rdy && !in_ready) rdy_low++;
      mon_n = 0; mon_k = -1;
      if (code_is_write)     begin mon_n++; mon_k = 0; end
      if (weight_is_write)   begin mon_n++; mon_k = 1; end
      if (input_is_write)    begin mon_n++; mon_k = 2; end
      if (label_is_write)    begin mon_n++; mon_k = 3; end
      if (locator_reset)     begin mon_n++; mon_k = 4; end
      if (controller_enable) begin mon_n++; mon_k = 5; end
      if (mon_n > 1) begin
        tests++; fails++;
        $display("FAIL onehot got=%0d strobes expected=1", mon_n);
      end else if (mon_n == 1) begin
        mon_got.kind = mon_k;
        mon_got.layer = 32'h0; mon_got.addr = 32'h0; mon_got.data = 48'h0;
        if (mon_k == 0) begin
          mon_got.addr = code_write_line;
          mon_got.data = {36'h0, code_write_data};
        end else if (mon_k < 4) begin
          mon_got.layer = mat_write_layer_index;
          mon_got.addr  = mat_write_row_index;
          mon_got.data  = mat_write_data;
        end
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe got kind=%0d addr=0x%0h data=0x%0h expected none",
                   mon_k, mon_got.addr, mon_got.data);
        end else begin
          mon_exp = sb.pop_front();
          if (mon_got.kind != mon_exp.kind || mon_got.layer !== mon_exp.layer ||
              mon_got.addr !== mon_exp.addr || mon_got.data !== mon_exp.data) begin
            fails++;
            $display("FAIL strobe got k=%0d l=0x%0h a=0x%0h d=0x%0h expected k=%0d l=0x%0h a=0x%0h d=0x%0h",
                     mon_got.kind, mon_got.layer, mon_got.addr, mon_got.data,
                     mon_exp.kind, mon_exp.layer, mon_exp.addr, mon_exp.data);
          end
        end
        if (mon_k < 4) begin
          tests++;
          if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_in_write got=%b expected=0", in_ready);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  guard;
    logic r;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 1) ? int'($urandom_range(1, 3)) : 0;
      repeat (g) begin in_valid = 1'b0; @(posedge clk_clk); #1; end
    end
    in_data = b; in_valid = 1'b1; guard = 0;
    do begin
      @(negedge clk_clk); r = in_ready;
      @(posedge clk_clk); #1;
      guard++;
    end while (!r && guard < 200);
    if (!r) begin
      tests++; fails++;
      $display("FAIL handshake_timeout got in_ready=0 expected=1 byte=0x%0h", b);
    end
    in_valid = 1'b0;
  endtask

  task automatic hdr(input logic [7:0] h, input logic [15:0] layer,
                     input logic [15:0] row, input logic [7:0] cnt);
    pkt.push_back(h);
    pkt.push_back(layer[15:8]); pkt.push_back(layer[7:0]);
    pkt.push_back(row[15:8]);   pkt.push_back(row[7:0]);
    pkt.push_back(cnt);
  endtask

  task automatic elem6(input logic [47:0] d);
    for (int i = 5; i >= 0; i--) pkt.push_back(d[i*8 +: 8]);
  endtask

  task automatic elem2(input logic [15:0] d);
    pkt.push_back(d[15:8]); pkt.push_back(d[7:0]);
  endtask

  task automatic send_pkt(input bit gaps, input bit add_csum, input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    foreach (pkt[i]) begin
      x ^= pkt[i];
      send_byte(pkt[i], gaps);
    end
`ifdef SWSEQ_CHECKSUM_EN
    if (add_csum) send_byte(corrupt ? (x ^ 8'h5A) : x, gaps);
`else
    if (add_csum && corrupt) x = 8'h00;
`endif
    pkt.delete();
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    @(posedge clk_clk); #1;
    while (busy && guard < 100) begin @(posedge clk_clk); #1; guard++; end
    check(name, {63'h0, busy}, 64'h0);
    repeat (2) @(posedge clk_clk);
    #1;
  endtask

  task automatic weight_test1(input bit gaps, input bit corrupt);
    hdr(8'h01, 16'h0002, 16'h0005, 8'h02);
    elem6(48'h000100020003);
    elem6(48'h0000000000FF);
    exp_push(1, 32'd2, 32'd5, 48'h000100020003);
    exp_push(1, 32'd2, 32'd6, 48'h0000000000FF);
    send_pkt(gaps, 1'b1, corrupt);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk_clk);
    #1;
    check("rst_in_ready", {63'h0, in_ready}, 64'h0);
    check("rst_busy_err", {62'h0, busy, err}, 64'h0);
    check("rst_strobes", {58'h0, code_is_write, weight_is_write, input_is_write,
                          label_is_write, locator_reset, controller_enable}, 64'h0);
    check("rst_addr", {mat_write_row_index, code_write_line}, 64'h0);
    check("rst_data", {4'h0, code_write_data, mat_write_data}, 64'h0);
    reset_reset_n = 1'b1;
    @(posedge clk_clk); #1;
    check("post_rst_ready", {63'h0, in_ready}, 64'h1);

    // 1: weight packet, with strobe latency check on the last byte
    hdr(8'h01, 16'h0002, 16'h0005, 8'h02);
    elem6(48'h000100020003);
    elem6(48'h0000000000FF);
    exp_push(1, 32'd2, 32'd5, 48'h000100020003);
    exp_push(1, 32'd2, 32'd6, 48'h0000000000FF);
    begin
      logic [7:0] last;
      last = pkt.pop_back();
      send_pkt(1'b0, 1'b0, 1'b0);
      send_byte(last, 1'b0);
      check("t1_latency", {62'h0, weight_is_write, in_ready}, 64'h2);
`ifdef SWSEQ_CHECKSUM_EN
      send_byte(8'h01 ^ 8'h00 ^ 8'h02 ^ 8'h00 ^ 8'h05 ^ 8'h02 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'hFF, 1'b0);
`endif
    end
    wait_idle("t1_idle");

    // 2: code packet, upper nibble of each element dropped
    hdr(8'h00, 16'h0000, 16'h0010, 8'h03);
    elem2(16'h0ABC); elem2(16'hFFFF); elem2(16'h0123);
    exp_push(0, 32'h0, 32'h10, 48'hABC);
    exp_push(0, 32'h0, 32'h11, 48'hFFF);
    exp_push(0, 32'h0, 32'h12, 48'h123);
    send_pkt(1'b0, 1'b1, 1'b0);
    wait_idle("t2_idle");

    // 3: header-only commands; HDR[7:3] ignored on the second
    exp_push(4, 32'h0, 32'h0, 48'h0);
    send_pkt_cmd(8'h04);
    wait_idle("t3_busy_reset");
    exp_push(5, 32'h0, 32'h0, 48'h0);
    send_pkt_cmd(8'hF5);
    wait_idle("t3_busy_enable");

    // CNT=0 means 256 elements; code line wraps past 0xFFFFFFFF
    hdr(8'h00, 16'hFFFF, 16'hFFFE, 8'h00);
    for (int i = 0; i < 256; i++) begin
      logic [15:0] d;
      logic [31:0] ln;
      d  = 16'hA000 + 16'(i * 37);
      ln = 32'hFFFFFFFE + 32'(i);
      elem2(d);
      exp_push(0, 32'h0, ln, {36'h0, d[11:0]});
    end
    send_pkt(1'b0, 1'b1, 1'b0);
    wait_idle("cnt256_idle");
    check("cnt256_drained", 64'(sb.size()), 64'h0);

    // 4: test 1 with random valid gaps; in_ready low only in the two WRITE cycles
    rdy_low = 0; cnt_rdy = 1'b1;
    weight_test1(1'b1, 1'b0);
    wait_idle("t4_idle");
    cnt_rdy = 1'b0;
    check("t4_ready_low_cycles", 64'(rdy_low), 64'd2);
    check("t4_err_clear", {63'h0, err}, 64'h0);

    // input target, row field on the matrix path
    hdr(8'h02, 16'h1234, 16'hABCD, 8'h01);
    elem6(48'hDEADBEEFCAFE);
    exp_push(2, 32'h1234, 32'hABCD, 48'hDEADBEEFCAFE);
    send_pkt(1'b0, 1'b1, 1'b0);
    wait_idle("input_idle");

    // 5: reserved header
    send_byte(8'h07, 1'b0);
    check("t5_err_set", {62'h0, err, busy}, 64'h2);
    repeat (3) @(posedge clk_clk);
    #1;
    check("t5_no_strobe", 64'(sb.size()), 64'h0);

    // 5b: reset in the middle of a label element
    hdr(8'h03, 16'h0001, 16'h0002, 8'h01);
    pkt.push_back(8'h11); pkt.push_back(8'h22); pkt.push_back(8'h33);
    send_pkt(1'b0, 1'b0, 1'b0);
    reset_reset_n = 1'b0;
    repeat (2) @(posedge clk_clk);
    #1;
    check("t5_rst_err_busy", {62'h0, err, busy}, 64'h0);
    reset_reset_n = 1'b1;
    repeat (3) @(posedge clk_clk);
    #1;
    hdr(8'h03, 16'h0001, 16'h0002, 8'h01);
    elem6(48'h112233445566);
    exp_push(3, 32'h1, 32'h2, 48'h112233445566);
    send_pkt(1'b0, 1'b1, 1'b0);
    wait_idle("t5_after_rst_idle");
    check("t5_after_rst_err", {63'h0, err}, 64'h0);

`ifdef SWSEQ_CHECKSUM_EN
    // 6: corrupted checksum -> both writes still happen, err set
    weight_test1(1'b0, 1'b1);
    wait_idle("t6_idle");
    check("t6_err_set", {63'h0, err}, 64'h1);
`endif

    check("final_drained", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic send_pkt_cmd(input logic [7:0] h);
    send_byte(h, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
